// File: rtl/rx_data_sampler.sv
// rx_data_sampler
//   Majority-vote data sampler for an oversampled UART-style receiver.
//   NUM_SAMPLES samples are taken around the middle of each bit, at
//   edge_cnt positions mid-H .. mid+H, where mid = prescale/2 - 1 and
//   H = (NUM_SAMPLES-1)/2. One clock after the last sample, the majority
//   result is registered onto sampled_bit and sample_valid pulses for
//   one cycle.
//
//   Optional feature macro: RX_SAMPLER_NOISE_DET_EN
//     defined   -> noise_flag reports a non-unanimous vote (registered)
//     undefined -> noise_flag is tied to 0 and has no register
//
// Ports
//   CLK           in   single clock, rising edge
//   RST           in   synchronous active-high reset
//   prescale      in   [PRESCALE_W] RX clocks per bit
//   RX_IN         in   serial line, already synchronous to CLK
//   data_samp_en  in   sampling enable from the RX FSM
//   edge_cnt      in   [PRESCALE_W] position within the current bit
//   sampled_bit   out  registered majority result
//   sample_valid  out  one-cycle pulse when sampled_bit is updated
//   noise_flag    out  last vote was not unanimous
//   cfg_err       out  registered, high while prescale < NUM_SAMPLES+1
//
// FSM states
//   state   | meaning
//   IDLE    | not sampling; waits for data_samp_en
//   COLLECT | capturing samples as edge_cnt crosses the window
//   VOTE    | all samples held; result is registered on the next edge

module rx_data_sampler #(
    parameter int PRESCALE_W  = 6,
    parameter int NUM_SAMPLES = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  RX_IN,
    input  logic                  data_samp_en,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_flag,
    output logic                  cfg_err
);

    localparam int HALF  = (NUM_SAMPLES - 1) / 2;
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    localparam logic [PRESCALE_W-1:0] MIN_PRESCALE = PRESCALE_W'(NUM_SAMPLES + 1);
    localparam logic [PRESCALE_W-1:0] HALF_P       = PRESCALE_W'(HALF);
    localparam logic [CNT_W-1:0]      HALF_C       = CNT_W'(HALF);
    localparam logic [CNT_W-1:0]      ALL_C        = CNT_W'(NUM_SAMPLES);

    generate
        if ((NUM_SAMPLES < 3) || (NUM_SAMPLES > 7) || ((NUM_SAMPLES % 2) == 0)) begin : g_bad_num_samples
            $error("rx_data_sampler: NUM_SAMPLES must be odd and in 3..7");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VOTE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_SAMPLES-1:0] sample_q, sample_d;
    logic [CNT_W-1:0]       ones_q, ones_d;
    logic                   sampled_bit_q, sampled_bit_d;
    logic                   sample_valid_q, sample_valid_d;
    logic                   cfg_err_q, cfg_err_d;

`ifdef RX_SAMPLER_NOISE_DET_EN
    logic                   noise_flag_q, noise_flag_d;
`endif

    logic                   cfg_bad;
    logic [PRESCALE_W-1:0]  mid;
    logic [PRESCALE_W-1:0]  win_lo;
    logic [PRESCALE_W-1:0]  win_hi;

    // Ones count is always rebuilt from the sample register, so a
    // position revisited within one bit overwrites rather than double counts.
    function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_SAMPLES-1:0] s);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            c = c + CNT_W'(s[k]);
        end
        return c;
    endfunction

    // Window tracks prescale combinationally; mid may wrap for tiny
    // prescale values but every use is gated by cfg_bad.
    always_comb begin
        cfg_bad = (prescale < MIN_PRESCALE);
        mid     = (prescale >> 1) - PRESCALE_W'(1);
        win_lo  = mid - HALF_P;
        win_hi  = mid + HALF_P;
    end

    always_comb begin
        state_d        = state_q;
        sample_d       = sample_q;
        ones_d         = ones_q;
        sampled_bit_d  = sampled_bit_q;
        sample_valid_d = 1'b0;
        cfg_err_d      = cfg_bad;
`ifdef RX_SAMPLER_NOISE_DET_EN
        noise_flag_d   = noise_flag_q;
`endif

        if (!data_samp_en) begin
            // Dropping the enable abandons any partial bit, even in VOTE.
            state_d  = IDLE;
            sample_d = '0;
            ones_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = COLLECT;
                    sample_d = '0;
                    ones_d   = '0;
                end
                COLLECT: begin
                    if (!cfg_bad) begin
                        for (int k = 0; k < NUM_SAMPLES; k++) begin
                            if (edge_cnt == (win_lo + PRESCALE_W'(k))) begin
                                sample_d[k] = RX_IN;
                            end
                        end
                        ones_d = count_ones(sample_d);
                        if (edge_cnt == win_hi) begin
                            state_d = VOTE;
                        end
                    end
                end
                VOTE: begin
                    state_d  = COLLECT;
                    sample_d = '0;
                    ones_d   = '0;
                    // A prescale that turned illegal mid-bit suppresses the result.
                    if (!cfg_bad) begin
                        sample_valid_d = 1'b1;
                        sampled_bit_d  = (ones_q > HALF_C);
`ifdef RX_SAMPLER_NOISE_DET_EN
                        noise_flag_d   = (ones_q != '0) && (ones_q != ALL_C);
`endif
                    end
                end
                default: begin
                    state_d  = IDLE;
                    sample_d = '0;
                    ones_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= IDLE;
            sample_q       <= '0;
            ones_q         <= '0;
            sampled_bit_q  <= 1'b0;
            sample_valid_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_q       <= sample_d;
            ones_q         <= ones_d;
            sampled_bit_q  <= sampled_bit_d;
            sample_valid_q <= sample_valid_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

`ifdef RX_SAMPLER_NOISE_DET_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            noise_flag_q <= 1'b0;
        end else begin
            noise_flag_q <= noise_flag_d;
        end
    end

    assign noise_flag = noise_flag_q;
`else
    assign noise_flag = 1'b0;
`endif

    assign sampled_bit  = sampled_bit_q;
    assign sample_valid = sample_valid_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Testbench for rx_data_sampler: two instances (NUM_SAMPLES 3 and 5) share
// all inputs; a per-bit reference model derives the expected vote from the
// window rules and the stimulus sequence.

module tb_rx_data_sampler;

    localparam int PW = 6;

`ifdef RX_SAMPLER_NOISE_DET_EN
    localparam bit NOISE_ON = 1'b1;
`else
    localparam bit NOISE_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic [PW-1:0] prescale;
    logic          RX_IN;
    logic          data_samp_en;
    logic [PW-1:0] edge_cnt;
    logic [1:0]    sampled_bit;
    logic [1:0]    sample_valid;
    logic [1:0]    noise_flag;
    logic [1:0]    cfg_err;

    int   checks   = 0;
    int   failures = 0;
    int   nsamp [2];
    logic exp_bit   [2];
    logic exp_noise [2];

    always #5 CLK = ~CLK;

    rx_data_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(3)) u_dut3 (
        .CLK          (CLK),
        .RST          (RST),
        .prescale     (prescale),
        .RX_IN        (RX_IN),
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .sampled_bit  (sampled_bit[0]),
        .sample_valid (sample_valid[0]),
        .noise_flag   (noise_flag[0]),
        .cfg_err      (cfg_err[0])
    );

    rx_data_sampler #(.PRESCALE_W(PW), .NUM_SAMPLES(5)) u_dut5 (
        .CLK          (CLK),
        .RST          (RST),
        .prescale     (prescale),
        .RX_IN        (RX_IN),
        .data_samp_en (data_samp_en),
        .edge_cnt     (edge_cnt),
        .sampled_bit  (sampled_bit[1]),
        .sample_valid (sample_valid[1]),
        .noise_flag   (noise_flag[1]),
        .cfg_err      (cfg_err[1])
    );

    task automatic check(input string tag, input int d, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%b expected=%b t=%0t", tag, nsamp[d], obs, exp, $time);
        end
    endtask

    task automatic check_all(input logic [1:0] vexp, input bit in_rst, input int p);
        for (int d = 0; d < 2; d++) begin
            check("sample_valid", d, sample_valid[d], vexp[d]);
            check("sampled_bit",  d, sampled_bit[d],  exp_bit[d]);
            check("noise_flag",   d, noise_flag[d],   exp_noise[d]);
            check("cfg_err",      d, cfg_err[d], (!in_rst && (p < nsamp[d] + 1)) ? 1'b1 : 1'b0);
        end
    endtask

    // One enabled cycle outside every window so both instances sit in COLLECT.
    task automatic lead_in(input int p);
        prescale     = PW'(p);
        edge_cnt     = PW'(p - 1);
        RX_IN        = 1'b0;
        data_samp_en = 1'b1;
        RST          = 1'b0;
        @(posedge CLK); #1;
        check_all(2'b00, 1'b0, p);
    endtask

    // One bit period: edges 0..p-1 with RX_IN = rx_bits[edge]. dup repeats
    // the mid edge with inverted data; enable low from sequence index drop;
    // RST pulsed at sequence index rst_idx (the bit is cut there).
    task automatic run_bit(input int p, input logic [31:0] rx_bits, input bit dup,
                           input int drop, input int rst_idx);
        int   seq_e [$];
        logic seq_rx [$];
        int   mid, h, lo, hi, idx_hi, ones;
        logic v;
        bit   will_vote [2];
        int   vidx [2];
        logic pb [2];
        logic pn [2];
        logic [1:0] vexp;

        mid = p / 2 - 1;
        for (int e = 0; e < p; e++) begin
            seq_e.push_back(e);
            seq_rx.push_back(rx_bits[e]);
            if (dup && e == mid) begin
                seq_e.push_back(e);
                seq_rx.push_back(!rx_bits[e]);
            end
        end

        for (int d = 0; d < 2; d++) begin
            will_vote[d] = 1'b0;
            vidx[d]      = -1;
            pb[d]        = 1'b0;
            pn[d]        = 1'b0;
            if (p >= nsamp[d] + 1) begin
                h  = (nsamp[d] - 1) / 2;
                lo = mid - h;
                hi = mid + h;
                idx_hi = -1;
                for (int i = 0; i < seq_e.size(); i++)
                    if (idx_hi < 0 && seq_e[i] == hi) idx_hi = i;
                ones = 0;
                for (int k = 0; k < nsamp[d]; k++) begin
                    v = 1'b0;
                    for (int i = 0; i <= idx_hi; i++)
                        if (seq_e[i] == lo + k) v = seq_rx[i];
                    ones += int'(v);
                end
                vidx[d]      = idx_hi + 1;
                will_vote[d] = (drop > vidx[d]) && (rst_idx < 0 || rst_idx > vidx[d]);
                pb[d]        = (ones > h);
                pn[d]        = NOISE_ON && (ones != 0) && (ones != nsamp[d]);
            end
        end

        for (int i = 0; i < seq_e.size(); i++) begin
            prescale     = PW'(p);
            edge_cnt     = PW'(seq_e[i]);
            RX_IN        = seq_rx[i];
            data_samp_en = (i < drop);
            RST          = (i == rst_idx);
            @(posedge CLK); #1;
            vexp = 2'b00;
            if (i == rst_idx) begin
                for (int d = 0; d < 2; d++) begin
                    exp_bit[d]   = 1'b0;
                    exp_noise[d] = 1'b0;
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (will_vote[d] && i == vidx[d]) begin
                    vexp[d]      = 1'b1;
                    exp_bit[d]   = pb[d];
                    exp_noise[d] = pn[d];
                end
            end
            check_all(vexp, (i == rst_idx), p);
            if (i == rst_idx) break;
        end
        RST = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int   p;
        int   drop;
        bit   dup;
        logic [31:0] rx;

        nsamp[0] = 3;
        nsamp[1] = 5;
        for (int d = 0; d < 2; d++) begin
            exp_bit[d]   = 1'b0;
            exp_noise[d] = 1'b0;
        end

        // Reset state
        RST          = 1'b1;
        data_samp_en = 1'b0;
        prescale     = PW'(16);
        edge_cnt     = '0;
        RX_IN        = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
            check_all(2'b00, 1'b1, 16);
        end
        RST = 1'b0;

        // All ones at 6,7,8 with prescale 16
        lead_in(16);
        run_bit(16, 32'h0000_01C0, 1'b0, 1000, -1);
        // 1,0,0 at 6,7,8
        run_bit(16, 32'h0000_0040, 1'b0, 1000, -1);
        // prescale 8, positions 1..5 = 0,1,1,0,1
        run_bit(8, 32'h0000_002C, 1'b0, 1000, -1);
        // All zeros, then an all-ones bit whose enable drops after edge 7
        run_bit(16, 32'h0000_0000, 1'b0, 1000, -1);
        run_bit(16, 32'hFFFF_FFFF, 1'b0, 8, -1);

        // prescale 4: illegal for five samples over three full bits
        lead_in(4);
        repeat (3) begin
            rx = $urandom;
            run_bit(4, rx, 1'b0, 1000, -1);
        end

        // Repeated mid position overwrites the sample
        lead_in(16);
        run_bit(16, 32'hFFFF_FFFF, 1'b1, 1000, -1);
        run_bit(10, 32'h0000_0000, 1'b1, 1000, -1);

        // Reset at edge 7, then a clean all-ones bit
        run_bit(16, 32'hFFFF_FFFF, 1'b0, 1000, -1);
        run_bit(16, 32'hFFFF_FFFF, 1'b0, 1000, 7);
        lead_in(16);
        run_bit(16, 32'hFFFF_FFFF, 1'b0, 1000, -1);

        // Randomized bits
        for (int n = 0; n < 30; n++) begin
            p    = $urandom_range(4, 24);
            rx   = $urandom;
            dup  = ($urandom_range(0, 3) == 0);
            drop = ($urandom_range(0, 4) == 0) ? $urandom_range(0, p - 1) : 1000;
            lead_in(p);
            run_bit(p, rx, dup, drop, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rx_data_sampler.md
RX_DATA_SAMPLER -- requirements
Module: rx_data_sampler

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6, width of prescale and edge_cnt (supports prescale up to 32 at default).
REQ-002 SHALL have parameter NUM_SAMPLES, default 3, samples per bit for the majority vote; legal values are odd 3..7, and any other value SHALL fail elaboration.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port prescale  input  PRESCALE_W  oversampling ratio, in RX clocks per bit.
REQ-006 SHALL have port RX_IN  input  1  serial RX line, already synchronous to CLK.
REQ-007 SHALL have port data_samp_en  input  1  sampling enable from the RX FSM.
REQ-008 SHALL have port edge_cnt  input  PRESCALE_W  edge position within the current bit, 0..prescale-1.
REQ-009 SHALL have port sampled_bit  output  1  registered majority result.
REQ-010 SHALL have port sample_valid  output  1  one-cycle pulse when sampled_bit is updated.
REQ-011 SHALL have port noise_flag  output  1  samples of the last vote were not unanimous.
REQ-012 SHALL have port cfg_err  output  1  registered; high while prescale is below the legal minimum.

Function
REQ-013 SHALL compute H = (NUM_SAMPLES-1)/2 and mid = floor(prescale/2) - 1; sample k (k = 0..NUM_SAMPLES-1) is taken at edge_cnt == mid - H + k.
REQ-014 SHALL treat prescale < NUM_SAMPLES+1 as illegal: cfg_err = 1 on the next cycle, no samples captured, sample_valid never asserted.
REQ-015 SHALL implement FSM states IDLE, COLLECT and VOTE.
REQ-016 SHALL transition IDLE->COLLECT on a clock edge with data_samp_en = 1 and clear the sample register and the ones-counter on entry.
REQ-017 SHALL, in COLLECT with data_samp_en = 1, store RX_IN into sample[k] and add it to a ones-counter (width clog2(NUM_SAMPLES+1)) when edge_cnt matches position k.
REQ-018 SHALL, at the edge capturing the last sample (edge_cnt == mid+H), also go to VOTE.
REQ-019 SHALL, in VOTE, on the next edge set sampled_bit = (ones > H), pulse sample_valid = 1 for exactly one cycle, and set noise_flag = 1 if ones is neither 0 nor NUM_SAMPLES, else 0.
REQ-020 SHALL, leaving VOTE, go to COLLECT if data_samp_en = 1 (sample register and counter cleared), else to IDLE.
REQ-021 SHALL, when data_samp_en = 0 in any state, go to IDLE on the next edge, discard partial samples and emit no sample_valid, including when en drops in VOTE.
REQ-022 SHALL hold sampled_bit and noise_flag between votes; they change only with a sample_valid pulse or reset.
REQ-023 SHALL give a latency of exactly 1 CLK from the last-sample edge to sample_valid high.
REQ-024 SHALL use edge_cnt values outside the sampling window only to wait; a repeated position in one bit overwrites that sample bit but SHALL NOT count it twice; the counter SHALL be recomputed from the sample register.
REQ-025 SHALL apply a prescale change immediately to the window positions; the bit in progress is not protected.

Reset
REQ-026 SHALL, with RST high at a rising CLK edge, set the FSM to IDLE, the sample register and counter to 0, and sampled_bit, sample_valid, noise_flag and cfg_err to 0.
REQ-027 SHALL, on reset during COLLECT or VOTE, abort the vote with no sample_valid pulse; sampling resumes on the first en-high edge after RST falls.

Configuration
REQ-028 SHALL, with macro RX_SAMPLER_NOISE_DET_EN defined, implement noise_flag as in REQ-019.
REQ-029 SHALL, without RX_SAMPLER_NOISE_DET_EN, tie noise_flag to constant 0 and omit its register; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL cover: N=3, prescale=16, RX_IN=1 at edge_cnt 6,7,8 -> sampled_bit=1, noise_flag=0, sample_valid pulse one cycle after edge 8.
REQ-031 SHALL cover: N=3, prescale=16, RX_IN 1,0,0 at edges 6,7,8 -> sampled_bit=0, noise_flag=1 (0 if macro undefined).
REQ-032 SHALL cover: N=5, prescale=8, positions 1..5 with RX_IN 0,1,1,0,1 -> sampled_bit=1, noise_flag=1.
REQ-033 SHALL cover: N=3, prescale=16, data_samp_en dropped after edge 7 -> no sample_valid and sampled_bit keeps its previous value.
REQ-034 SHALL cover: N=5, prescale=4 -> cfg_err=1, with no sample_valid over 3 full bit periods.
REQ-035 SHALL cover: RST asserted at edge 7 of a bit -> all outputs 0 next cycle; the following full bit of all-1 gives sampled_bit=1.
